// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered WIDTH-bit output among 8 requesters.
// Optional multi-beat grants are enabled by defining RR_ARB_BURST_EN.
module mux8_rr_arbiter #(
    parameter int WIDTH  = 4,
    parameter int SWIDTH = 3,
    parameter int BURST  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        req,
    input  logic [WIDTH-1:0]  i0,
    input  logic [WIDTH-1:0]  i1,
    input  logic [WIDTH-1:0]  i2,
    input  logic [WIDTH-1:0]  i3,
    input  logic [WIDTH-1:0]  i4,
    input  logic [WIDTH-1:0]  i5,
    input  logic [WIDTH-1:0]  i6,
    input  logic [WIDTH-1:0]  i7,
    input  logic              o_ready,
    output logic [WIDTH-1:0]  o,
    output logic              o_valid,
    output logic [SWIDTH-1:0] sel,
    output logic [7:0]        gnt,
    output logic              busy
);

    localparam int NREQ = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state_r, state_s;
    logic [SWIDTH-1:0]   ptr_r, ptr_s;
    logic [WIDTH-1:0]    o_r, o_s;
    logic                o_valid_r, o_valid_s;
    logic [SWIDTH-1:0]   sel_r, sel_s;
    logic [NREQ-1:0]     gnt_r, gnt_s;
    logic                busy_r;
    logic [3:0]          beat_r, beat_s;

    logic [WIDTH-1:0]    din_s [NREQ];
    logic [SWIDTH:0]     pick_idle_s;
    logic [SWIDTH:0]     pick_next_s;
    logic [SWIDTH-1:0]   ptr_next_s;
    logic                burst_en_s;
    logic                burst_keep_s;

    // First set bit of r searching p, p+1, ... with wrap; result is {found, index}.
    function automatic logic [SWIDTH:0] rr_pick(input logic [NREQ-1:0] r,
                                                 input logic [SWIDTH-1:0] p);
        logic              found;
        logic [SWIDTH-1:0] win;
        logic [SWIDTH-1:0] idx;
        found = 1'b0;
        win   = '0;
        for (int j = 0; j < NREQ; j++) begin
            idx = p + SWIDTH'(j);
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    assign din_s[0] = i0;
    assign din_s[1] = i1;
    assign din_s[2] = i2;
    assign din_s[3] = i3;
    assign din_s[4] = i4;
    assign din_s[5] = i5;
    assign din_s[6] = i6;
    assign din_s[7] = i7;

`ifdef RR_ARB_BURST_EN
    assign burst_en_s = 1'b1;
`else
    assign burst_en_s = 1'b0;
`endif

    // The just-served channel is masked so a lone requester yields a one-cycle gap.
    assign ptr_next_s   = sel_r + SWIDTH'(1);
    assign pick_idle_s  = rr_pick(req, ptr_r);
    assign pick_next_s  = rr_pick(req & ~gnt_r, ptr_next_s);
    assign burst_keep_s = burst_en_s && req[sel_r] &&
                          (({1'b0, beat_r} + 5'd1) < 5'(BURST));

    // Next-state and next-output decode for the IDLE/GRANT sequencer.
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        o_s       = o_r;
        o_valid_s = o_valid_r;
        sel_s     = sel_r;
        gnt_s     = gnt_r;
        beat_s    = beat_r;
        case (state_r)
            IDLE: begin
                if (pick_idle_s[SWIDTH]) begin
                    sel_s     = pick_idle_s[SWIDTH-1:0];
                    gnt_s     = NREQ'(1) << pick_idle_s[SWIDTH-1:0];
                    o_s       = din_s[pick_idle_s[SWIDTH-1:0]];
                    o_valid_s = 1'b1;
                    beat_s    = 4'd0;
                    state_s   = GRANT;
                end else begin
                    state_s   = IDLE;
                end
            end
            GRANT: begin
                if (!o_ready) begin
                    state_s = GRANT;
                end else if (burst_keep_s) begin
                    o_s    = din_s[sel_r];
                    beat_s = beat_r + 4'd1;
                end else begin
                    ptr_s = ptr_next_s;
                    if (pick_next_s[SWIDTH]) begin
                        sel_s  = pick_next_s[SWIDTH-1:0];
                        gnt_s  = NREQ'(1) << pick_next_s[SWIDTH-1:0];
                        o_s    = din_s[pick_next_s[SWIDTH-1:0]];
                        beat_s = 4'd0;
                    end else begin
                        o_valid_s = 1'b0;
                        gnt_s     = '0;
                        state_s   = IDLE;
                    end
                end
            end
            default: begin
                state_s   = IDLE;
                o_valid_s = 1'b0;
                gnt_s     = '0;
            end
        endcase
    end

    // State and output registers; reset drops any word in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            ptr_r     <= '0;
            o_r       <= '0;
            o_valid_r <= 1'b0;
            sel_r     <= '0;
            gnt_r     <= '0;
            busy_r    <= 1'b0;
            beat_r    <= 4'd0;
        end else begin
            state_r   <= state_s;
            ptr_r     <= ptr_s;
            o_r       <= o_s;
            o_valid_r <= o_valid_s;
            sel_r     <= sel_s;
            gnt_r     <= gnt_s;
            busy_r    <= (state_s == GRANT);
            beat_r    <= beat_s;
        end
    end

    assign o       = o_r;
    assign o_valid = o_valid_r;
    assign sel     = sel_r;
    assign gnt     = gnt_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_mux8_rr_arbiter;

    localparam int BURST = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [3:0] d [8];
    logic       o_ready;
    logic [3:0] o;
    logic       o_valid;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux8_rr_arbiter #(.WIDTH(4), .SWIDTH(3), .BURST(BURST)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .i0(d[0]), .i1(d[1]), .i2(d[2]), .i3(d[3]),
        .i4(d[4]), .i5(d[5]), .i6(d[6]), .i7(d[7]),
        .o_ready(o_ready), .o(o), .o_valid(o_valid), .sel(sel), .gnt(gnt), .busy(busy)
    );

    typedef struct {
        int       ptr;
        bit       valid;
        bit [3:0] o;
        int       sel;
        bit [7:0] gnt;
        int       beat;
    } mstate_t;

    mstate_t m = '{default: 0};

    function automatic int pick(bit [7:0] r, int p);
        for (int j = 0; j < 8; j++) begin
            if (r[(p + j) % 8]) return (p + j) % 8;
        end
        return -1;
    endfunction

    function automatic mstate_t model_step(mstate_t s, logic rn, logic [7:0] r,
                                           logic [31:0] dv, logic rdy);
        mstate_t n;
        int      k;
        n = s;
        if (!rn) begin
            n = '{default: 0};
            return n;
        end
        if (!s.valid) begin
            k = pick(r, s.ptr);
            if (k >= 0) begin
                n.valid = 1; n.sel = k; n.gnt = 8'(1 << k); n.o = dv[4*k +: 4]; n.beat = 0;
            end
        end else if (rdy) begin
`ifdef RR_ARB_BURST_EN
            if (r[s.sel] && (s.beat + 1 < BURST)) begin
                n.o = dv[4*s.sel +: 4];
                n.beat = s.beat + 1;
                return n;
            end
`endif
            n.ptr = (s.sel + 1) % 8;
            k = pick(r & ~s.gnt, n.ptr);
            if (k >= 0) begin
                n.sel = k; n.gnt = 8'(1 << k); n.o = dv[4*k +: 4]; n.beat = 0;
            end else begin
                n.valid = 0; n.gnt = 8'h00;
            end
        end
        return n;
    endfunction

    always @(posedge clk)
        m <= model_step(m, rst_n, req, {d[7], d[6], d[5], d[4], d[3], d[2], d[1], d[0]}, o_ready);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 8'h00; o_ready = 1'b0;
        for (int k = 0; k < 8; k++) d[k] = 4'h0;
        tick(); tick();
        checks++;
        if ({o, o_valid, sel, gnt, busy} !== 17'h0) begin
            errors++;
            $display("FAIL reset_state: got o=%h v=%b sel=%0d gnt=%h busy=%b, need all zero",
                     o, o_valid, sel, gnt, busy);
        end
        rst_n = 1'b1; req = 8'h01; d[0] = 4'hA;
        tick(); tick();
        checks++;
        if ({o_valid, o, gnt, busy} !== {1'b1, 4'hA, 8'h01, 1'b1}) begin
            errors++;
            $display("FAIL reset_pre_grant: got v=%b o=%h gnt=%h busy=%b, need v=1 o=a gnt=01 busy=1",
                     o_valid, o, gnt, busy);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({o, o_valid, sel, gnt, busy} !== 17'h0) begin
            errors++;
            $display("FAIL reset_mid_grant: got o=%h v=%b sel=%0d gnt=%h busy=%b, need all zero",
                     o, o_valid, sel, gnt, busy);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({o_valid, sel, o, gnt} !== {1'b1, 3'd0, 4'hA, 8'h01}) begin
            errors++;
            $display("FAIL reset_regrant: got v=%b sel=%0d o=%h gnt=%h, need v=1 sel=0 o=a gnt=01",
                     o_valid, sel, o, gnt);
        end
        req = 8'h00; o_ready = 1'b1;
        tick(); tick();
    endtask

    task automatic test_single();
        req = 8'h20; d[5] = 4'h7; o_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            checks++;
            if ({o_valid, busy, sel, o, gnt} !==
                {(n % 2 == 0), (n % 2 == 0), 3'd5, 4'h7, ((n % 2 == 0) ? 8'h20 : 8'h00)}) begin
                errors++;
                $display("FAIL single_cycle%0d: got v=%b busy=%b sel=%0d o=%h gnt=%h, need v=%0d sel=5 o=7",
                         n, o_valid, busy, sel, o, gnt, (n % 2 == 0));
            end
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        req = 8'hFF; o_ready = 1'b1;
        for (int k = 0; k < 8; k++) d[k] = 4'(k);
        for (int n = 0; n < 9; n++) begin
            tick();
            checks++;
            if ({o_valid, sel, o, gnt} !== {1'b1, 3'(n % 8), 4'(n % 8), 8'(1 << (n % 8))}) begin
                errors++;
                $display("FAIL rr_step%0d: got v=%b sel=%0d o=%h gnt=%h, need v=1 sel=%0d",
                         n, o_valid, sel, o, gnt, n % 8);
            end
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_backpressure();
        req = 8'h0C; d[2] = 4'h9; d[3] = 4'h3; o_ready = 1'b0;
        tick();
        for (int n = 0; n < 5; n++) begin
            if (n == 2) d[2] = 4'h5;
            tick();
            checks++;
            if ({o_valid, sel, o, gnt} !== {1'b1, 3'd2, 4'h9, 8'h04}) begin
                errors++;
                $display("FAIL stall_cycle%0d: got v=%b sel=%0d o=%h gnt=%h, need v=1 sel=2 o=9 gnt=04",
                         n, o_valid, sel, o, gnt);
            end
        end
        o_ready = 1'b1;
        tick();
        checks++;
        if ({o_valid, sel, o, gnt} !== {1'b1, 3'd3, 4'h3, 8'h08}) begin
            errors++;
            $display("FAIL stall_release: got v=%b sel=%0d o=%h gnt=%h, need v=1 sel=3 o=3 gnt=08",
                     o_valid, sel, o, gnt);
        end
        req = 8'h00;
        tick();
        checks++;
        if ({o_valid, gnt, busy} !== 10'h0) begin
            errors++;
            $display("FAIL stall_idle: got v=%b gnt=%h busy=%b, need 0", o_valid, gnt, busy);
        end
    endtask

    task automatic test_wrap();
        req = 8'h20; o_ready = 1'b1;
        tick();
        req = 8'h00;
        tick();
        req = 8'h41; d[6] = 4'hE; d[0] = 4'h1;
        tick();
        checks++;
        if ({o_valid, sel, o, gnt} !== {1'b1, 3'd6, 4'hE, 8'h40}) begin
            errors++;
            $display("FAIL wrap_ch6: got v=%b sel=%0d o=%h gnt=%h, need v=1 sel=6 o=e gnt=40",
                     o_valid, sel, o, gnt);
        end
        req = 8'h01;
        tick();
        checks++;
        if ({o_valid, sel, o, gnt} !== {1'b1, 3'd0, 4'h1, 8'h01}) begin
            errors++;
            $display("FAIL wrap_ch0: got v=%b sel=%0d o=%h gnt=%h, need v=1 sel=0 o=1 gnt=01",
                     o_valid, sel, o, gnt);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_burst();
`ifdef RR_ARB_BURST_EN
        int exp_sel[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        int nexp = 9;
`else
        int exp_sel[4] = '{0, 1, 0, 1};
        int nexp = 4;
`endif
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        req = 8'h03; d[0] = 4'h1; d[1] = 4'h2; o_ready = 1'b1;
        for (int n = 0; n < nexp; n++) begin
            tick();
            checks++;
            if ({o_valid, sel, o} !== {1'b1, 3'(exp_sel[n]), 4'(exp_sel[n] + 1)}) begin
                errors++;
                $display("FAIL burst_step%0d: got v=%b sel=%0d o=%h, need v=1 sel=%0d o=%0d",
                         n, o_valid, sel, o, exp_sel[n], exp_sel[n] + 1);
            end
        end
        req = 8'h00;
        tick(); tick();
    endtask

    task automatic test_random();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int n = 0; n < 600; n++) begin
            rst_n   = ($urandom_range(0, 99) != 0);
            o_ready = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 2))
                0: req = 8'($urandom);
                1: req = 8'(1 << $urandom_range(0, 7));
                default: req = 8'($urandom) & 8'($urandom);
            endcase
            for (int k = 0; k < 8; k++) d[k] = 4'($urandom);
            tick();
            checks++;
            if ({o, o_valid, sel, gnt, busy} !==
                {m.o, m.valid, 3'(m.sel), m.gnt, m.valid}) begin
                errors++;
                $display("FAIL random_cycle%0d: got o=%h v=%b sel=%0d gnt=%h busy=%b, need o=%h v=%b sel=%0d gnt=%h",
                         n, o, o_valid, sel, gnt, busy, m.o, m.valid, m.sel, m.gnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
